// File: rtl/dmem_rmw_ctrl.sv
// MEM-stage data-memory controller. Loads and word stores go straight to a
// single-port synchronous RAM. Byte and halfword stores become a two-cycle
// read-modify-write: read the word, then merge the lane and write it back.
module dmem_rmw_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_wen,
  input  logic [1:0]        mem_maskMode,
  input  logic              mem_unsigned,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              rmw_busy,
  output logic              misalign
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_off;
  logic [1:0]        lat_mode;
  logic              lat_uns;
  logic [31:0]       lat_wdata;

  logic        idle_req, acc, ld_go, st_sub, st_word;
  logic [31:0] merged, shifted;

  // Request decode; anything arriving during RMW_WR is ignored outright.
  always_comb begin
    idle_req = mem_valid && (state == IDLE);
    misalign = idle_req && (((mem_maskMode == 2'b01) && mem_addr[0]) ||
                            ((mem_maskMode == 2'b10) && (mem_addr[1:0] != 2'b00)) ||
                            (mem_maskMode == 2'b11));
    acc      = idle_req && !misalign;
    ld_go    = acc && !mem_wen;
    st_sub   = acc && mem_wen && !mem_maskMode[1];
    st_word  = acc && mem_wen && (mem_maskMode == 2'b10);
  end

  // State register; rmw_busy is the registered RMW_WR flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a sub-word store always spends exactly one write-back cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (st_sub) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch what the following cycle needs: load alignment or the RMW operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_off   <= '0;
      lat_mode  <= '0;
      lat_uns   <= 1'b0;
      lat_wdata <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= ld_go;
      if (ld_go || st_sub) begin
        lat_off  <= mem_addr[1:0];
        lat_mode <= mem_maskMode;
      end
      if (ld_go) lat_uns <= mem_unsigned;
      if (st_sub) begin
        lat_addr  <= mem_addr[ADDR_W+1:2];
        lat_wdata <= mem_wdata;
      end
    end
  end

  // Merge the latched store lane into the word read in the previous cycle.
  always_comb begin
    merged = ram_rdata;
    if (lat_mode[0]) merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata[15:0];
    else             merged[{lat_off, 3'b000} +: 8]      = lat_wdata[7:0];
  end

  // Outputs: RAM port drive, gated off while reset is held.
  always_comb begin
    rmw_busy = (state == RMW_WR);
    if (rmw_busy) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = lat_addr;
      ram_wdata = merged;
    end else begin
      ram_en    = acc;
      ram_we    = st_word;
      ram_addr  = mem_addr[ADDR_W+1:2];
      ram_wdata = mem_wdata;
    end
    ram_en = ram_en && rst_n;
    ram_we = ram_we && rst_n;
  end

  // Load result: align the returned word, then sign- or zero-extend.
  always_comb begin
    shifted = ram_rdata >> {lat_off, 3'b000};
    case (lat_mode)
      2'b00:   rd_data = {{24{!lat_uns && shifted[7]}}, shifted[7:0]};
      2'b01:   rd_data = {{16{!lat_uns && shifted[15]}}, shifted[15:0]};
      default: rd_data = ram_rdata;
    endcase
  end

endmodule
